carry_chain_sequencer: RTL

CARRY_CHAIN_SEQUENCER -- requirements
Module: carry_chain_sequencer

---
 rtl/carry_chain_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/carry_chain_sequencer.sv
// ---------------------------------------------------------------------------------------------
// carry_chain_sequencer
//
// Two-requester adder front end. Requests are arbitrated round-robin, one operation is
// accepted at a time, and the sum is formed one 4-bit slice per clock. Each slice uses a
// mux-based carry chain where S = A ^ B selects the incoming carry and A acts as the
// generate term. The result is then held until the consumer takes it.
//
// Parameters
//   WIDTH      operand width. It must be a multiple of 4 and at least 4.
//
// Ports
//   clk        clock. All state changes on its rising edge.
//   rst_n      asynchronous active-low reset.
//   req_valid  per-requester request strobe (bit i = requester i).
//   req_ready  one-hot grant. It is only ever non-zero while idle.
//   req_a      operand A, packed per requester in [i*WIDTH +: WIDTH].
//   req_b      operand B, packed like req_a.
//   req_cin    carry-in, one bit per requester.
//   rsp_valid  a result is presented.
//   rsp_ready  the consumer accepts the result.
//   rsp_id     index of the requester that owns the result.
//   rsp_sum    A + B + cin, modulo 2^WIDTH.
//   rsp_cout   carry out of the MSB.
//   rsp_ovf    signed overflow: carry into the MSB XOR carry out of the MSB.
//   busy       high whenever an operation is in flight or waiting to be taken.
// ---------------------------------------------------------------------------------------------
module carry_chain_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_sum,
    output logic               rsp_cout,
    output logic               rsp_ovf,
    output logic               busy
);

    localparam int unsigned NIB = WIDTH / 4;
    // The slice counter is kept at least one bit wide so that WIDTH = 4 stays legal.
    localparam int unsigned KW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NIB - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             id_q, id_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // -----------------------------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------------------------
    logic       grant_idx;
    logic [1:0] grant;
    logic       accept;

    always_comb begin
        // When both requesters are valid the pointer wins. Otherwise the single valid one wins.
        grant_idx = (req_valid == 2'b11) ? ptr_q : req_valid[1];
        grant     = 2'b00;
        // The grant is gated by rst_n so that req_ready reads 0 as soon as reset is asserted.
        if ((state_q == StIdle) && rst_n && (req_valid != 2'b00)) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end
    end

    assign req_ready = grant;
    assign accept    = (grant & req_valid) != 2'b00;

    // -----------------------------------------------------------------------------------------
    // One 4-bit carry-chain slice, selected by the slice index
    // -----------------------------------------------------------------------------------------
    logic [3:0] a_sl;
    logic [3:0] b_sl;
    logic [3:0] s_sl;
    logic [3:0] ci_sl;
    logic [3:0] co_sl;
    logic [3:0] sum_sl;

    always_comb begin
        a_sl = 4'h0;
        b_sl = 4'h0;
        for (int unsigned n = 0; n < NIB; n++) begin
            if (k_q == KW'(n)) begin
                a_sl = a_q[4*n +: 4];
                b_sl = b_q[4*n +: 4];
            end
        end

        s_sl = a_sl ^ b_sl;

        // Each bit's carry mux feeds the next bit. This is written out so that there is no
        // apparent loop through a vector.
        ci_sl[0] = carry_q;
        co_sl[0] = s_sl[0] ? ci_sl[0] : a_sl[0];
        ci_sl[1] = co_sl[0];
        co_sl[1] = s_sl[1] ? ci_sl[1] : a_sl[1];
        ci_sl[2] = co_sl[1];
        co_sl[2] = s_sl[2] ? ci_sl[2] : a_sl[2];
        ci_sl[3] = co_sl[2];
        co_sl[3] = s_sl[3] ? ci_sl[3] : a_sl[3];

        sum_sl = s_sl ^ ci_sl;
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        id_d    = id_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // Operands are captured here, so later changes on the request bus are ignored.
                    a_d     = grant_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                    b_d     = grant_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                    carry_d = req_cin[grant_idx];
                    id_d    = grant_idx;
                    ptr_d   = ~grant_idx;
                    k_d     = '0;
                    state_d = StRun;
                end
            end

            StRun: begin
                for (int unsigned n = 0; n < NIB; n++) begin
                    if (k_q == KW'(n)) begin
                        sum_d[4*n +: 4] = sum_sl;
                    end
                end
                carry_d = co_sl[3];
                k_d     = k_q + 1'b1;
                if (k_q == LAST_K) begin
                    cout_d  = co_sl[3];
                    ovf_d   = co_sl[2] ^ co_sl[3];
                    state_d = StDone;
                end
            end

            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign rsp_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;

endmodule
